// File: rtl/tc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tc_pkg                                                           |
// | Purpose : Shared geometry of the tensor-core D buffer and the writeback    |
// |           FSM state encoding.                                              |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tc_pkg;

   localparam int M       = 16;            // rows in the D buffer
   localparam int N       = 16;            // elements per row
   localparam int DW_DATA = 16;            // element width
   localparam int DW_MEM  = N * DW_DATA;   // one memory word carries one full row
   localparam int DW_COL  = 4;             // row index width, 2**DW_COL >= M

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } tc_state_e;

endpackage : tc_pkg
`default_nettype wire

// File: rtl/tc_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tc_wb_fifo                                                       |
// | Purpose : Small synchronous FIFO buffering rows between the D buffer read  |
// |           side and the memory write channel.                               |
// | Ports   : clk, reset_n (async, active-low)                                 |
// |           push_i/wdata_i  - write side                                     |
// |           pop_i/rdata_o   - read side, rdata_o shows the head entry        |
// |           count_o/empty_o - occupancy                                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tc_wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule : tc_wb_fifo
`default_nettype wire

// File: rtl/tc_dwriteback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tc_dwriteback                                                    |
// | Purpose : Drains the finished D matrix out of the D buffer row-read port   |
// |           and writes one full row per memory write on a valid/ready bus.   |
// | Ports   : clk, reset_n (async, active-low)                                 |
// |           start/base_addr/row_stride - drain request                       |
// |           busy/done                  - status                              |
// |           row_out/D_row_out          - D buffer read port                  |
// |           mem_w*                     - memory write channel                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tc_dwriteback
   import tc_pkg::*;
#(
   parameter int DW_ADDR    = 32,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [DW_ADDR-1:0]   base_addr,
   input  logic [DW_ADDR-1:0]   row_stride,
   output logic                 busy,
   output logic                 done,
   output logic [DW_COL-1:0]    row_out,
   input  logic [N*DW_DATA-1:0] D_row_out,
   output logic                 mem_wvalid,
   input  logic                 mem_wready,
   output logic [DW_ADDR-1:0]   mem_waddr,
   output logic [DW_MEM-1:0]    mem_wdata
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   tc_state_e          state_q,     state_d;
   logic [DW_COL-1:0]  issue_row_q, issue_row_d;
   logic [RD_LAT-1:0]  pipe_q,      pipe_d;
   logic [DW_ADDR-1:0] addr_q,      addr_d;
   logic [DW_ADDR-1:0] stride_q,    stride_d;

   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_credit_ok;
   logic               w_fifo_empty;
   logic [CW-1:0]      w_fifo_count;
   logic [DW_MEM-1:0]  w_fifo_rdata;

   // Every read in the tag pipe already owns a FIFO slot; a pop this cycle
   // frees one. Written as an add on both sides to avoid an unsigned borrow.
   always_comb begin
      w_pop       = !w_fifo_empty && mem_wready;
      w_push      = pipe_q[RD_LAT-1];
      w_credit_ok = (32'(w_fifo_count) + 32'($countones(pipe_q)))
                    < (32'(FIFO_DEPTH) + 32'(w_pop));
      w_issue     = (state_q == ISSUE) && w_credit_ok;
   end

   always_comb begin
      state_d     = state_q;
      issue_row_d = issue_row_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      // New tag enters at bit 0, the oldest leaves from the MSB.
      pipe_d      = RD_LAT'({pipe_q, w_issue});

      // Running address: one stride per accepted write, wraps naturally.
      if (w_pop) begin
         addr_d = addr_q + stride_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = ISSUE;
               issue_row_d = '0;
               addr_d      = base_addr;
               stride_d    = row_stride;
            end
         end
         ISSUE: begin
            if (w_issue) begin
               // The index parks on the last row rather than stepping past it.
               if (issue_row_q == DW_COL'(M - 1)) begin
                  state_d = DRAIN;
               end else begin
                  issue_row_d = issue_row_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if ((pipe_q == '0) && w_fifo_empty) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         issue_row_q <= '0;
         pipe_q      <= '0;
         addr_q      <= '0;
         stride_q    <= '0;
      end else begin
         state_q     <= state_d;
         issue_row_q <= issue_row_d;
         pipe_q      <= pipe_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
      end
   end

   tc_wb_fifo #(
      .WIDTH (DW_MEM),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (w_push),
      .wdata_i (D_row_out),
      .pop_i   (w_pop),
      .rdata_o (w_fifo_rdata),
      .count_o (w_fifo_count),
      .empty_o (w_fifo_empty)
   );

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign row_out    = issue_row_q;
   assign mem_wvalid = !w_fifo_empty;
   assign mem_waddr  = addr_q;
   assign mem_wdata  = w_fifo_rdata;

endmodule : tc_dwriteback
`default_nettype wire

// File: tb/tb_tc_dwriteback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tc_dwriteback                                                 |
// | Purpose : Directed self-checking bench for tc_dwriteback with a one-cycle  |
// |           D buffer read model.                                             |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tc_dwriteback;
   import tc_pkg::*;

   localparam int DW_ADDR    = 32;
   localparam int RD_LAT     = 1;
   localparam int FIFO_DEPTH = 2;
   localparam int LAT        = M + RD_LAT + 2;

   logic                 clk;
   logic                 reset_n;
   logic                 start;
   logic [DW_ADDR-1:0]   base_addr;
   logic [DW_ADDR-1:0]   row_stride;
   logic                 busy;
   logic                 done;
   logic [DW_COL-1:0]    row_out;
   logic [N*DW_DATA-1:0] D_row_out;
   logic                 mem_wvalid;
   logic                 mem_wready;
   logic [DW_ADDR-1:0]   mem_waddr;
   logic [DW_MEM-1:0]    mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   tc_dwriteback #(
      .DW_ADDR    (DW_ADDR),
      .RD_LAT     (RD_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .row_stride (row_stride),
      .busy       (busy),
      .done       (done),
      .row_out    (row_out),
      .D_row_out  (D_row_out),
      .mem_wvalid (mem_wvalid),
      .mem_wready (mem_wready),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row r, element j holds r*16+j.
   function automatic logic [DW_MEM-1:0] row_pat(input int r);
      logic [DW_MEM-1:0] v;
      for (int j = 0; j < N; j++) begin
         v[j*DW_DATA +: DW_DATA] = 16'(r * 16 + j);
      end
      return v;
   endfunction

   // D buffer outside read port: one registered cycle of latency.
   always_ff @(posedge clk) begin
      D_row_out <= row_pat(int'(row_out));
   end

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready high, 1: random ready, 2: ready low 20 cycles,
   // 4: extra starts while busy and in the DONE cycle, 5: reset at row 7
   task automatic run_drain(input logic [31:0] base, input logic [31:0] stride, input int mode);
      int          wr;
      int          dones;
      int          done_k;
      logic        stall;
      logic [31:0] s_addr;
      logic [255:0] s_data;
      logic [31:0] exp_a;
      wr     = 0;
      dones  = 0;
      done_k = -1;
      stall  = 1'b0;
      s_addr = '0;
      s_data = '0;
      base_addr  = base;
      row_stride = stride;
      mem_wready = 1'b1;
      start      = 1'b1;
      tick();
      for (int k = 0; k < 200; k++) begin
         if (k > 0) tick();
         start = (mode == 4 && (k == 5 || k == LAT)) ? 1'b1 : 1'b0;
         case (mode)
            1:       mem_wready = 1'($urandom_range(0, 1));
            2:       mem_wready = (k < 20) ? 1'b0 : 1'b1;
            default: mem_wready = 1'b1;
         endcase
         #1;
         if (k == 0) check_val("busy_after_start", 256'(busy), 256'(1));
         if (mode == 2 && k == 19) check_val("row_out_stalled", 256'(row_out), 256'(FIFO_DEPTH));
         if (stall) begin
            check_val("wvalid_hold", 256'(mem_wvalid), 256'(1));
            check_val("waddr_stable", 256'(mem_waddr), 256'(s_addr));
            check_val("wdata_stable", 256'(mem_wdata), s_data);
         end
         if (mem_wvalid && mem_wready) begin
            exp_a = base + stride * 32'(wr);
            check_val("waddr", 256'(mem_waddr), 256'(exp_a));
            check_val("wdata", 256'(mem_wdata), 256'(row_pat(wr)));
            wr++;
         end
         stall  = mem_wvalid && !mem_wready;
         s_addr = mem_waddr;
         s_data = 256'(mem_wdata);
         if (done) begin
            dones++;
            if (done_k < 0) done_k = k;
         end
         if (mode == 5 && wr == 7) begin
            reset_n = 1'b0;
            #1;
            check_val("abort_wvalid", 256'(mem_wvalid), 256'(0));
            check_val("abort_busy", 256'(busy), 256'(0));
            check_val("abort_row_out", 256'(row_out), 256'(0));
            check_val("abort_waddr", 256'(mem_waddr), 256'(0));
            check_val("abort_wdata", 256'(mem_wdata), 256'(0));
            for (int i = 0; i < 3; i++) begin
               tick();
               check_val("abort_no_done", 256'(done), 256'(0));
            end
            reset_n = 1'b1;
            tick();
            check_val("abort_writes", 256'(wr), 256'(7));
            check_val("abort_dones", 256'(dones), 256'(0));
            return;
         end
         if (done_k >= 0 && k >= done_k + 3) break;
      end
      start = 1'b0;
      check_val("writes", 256'(wr), 256'(M));
      check_val("dones", 256'(dones), 256'(1));
      check_val("busy_idle", 256'(busy), 256'(0));
      check_val("wvalid_idle", 256'(mem_wvalid), 256'(0));
      if (mode == 0 || mode == 4) check_val("done_latency", 256'(done_k), 256'(LAT));
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      row_stride = '0;
      mem_wready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 256'(busy), 256'(0));
      check_val("rst_done", 256'(done), 256'(0));
      check_val("rst_row_out", 256'(row_out), 256'(0));
      check_val("rst_wvalid", 256'(mem_wvalid), 256'(0));
      check_val("rst_waddr", 256'(mem_waddr), 256'(0));
      check_val("rst_wdata", 256'(mem_wdata), 256'(0));
      reset_n = 1'b1;
      tick();

      run_drain(32'h0000_1000, 32'h20, 0);
      run_drain(32'h0000_1000, 32'h20, 1);
      run_drain(32'h0000_1000, 32'h20, 2);
      run_drain(32'h0000_1000, 32'h20, 4);
      run_drain(32'h0000_1000, 32'h20, 5);
      run_drain(32'h0000_1000, 32'h20, 0);
      run_drain(32'hFFFF_FFF0, 32'h20, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_tc_dwriteback
`default_nettype wire
